pll_lock_supervisor: RTL

Supervises the video PLL from the free-running init clock. It issues the PLL reset pulse and filters the PLL lock signal. It releases the downstream system reset only after lock has been stable for a programmable time. On lock loss or lock timeout it re-resets the PLL with bounded retries. It sits between the PLL wrapper's lock/reset pins and the reset tree of the upscaler pixel and capture domains.

---
 rtl/pll_lock_supervisor_if.sv | 44 ++++
 rtl/pll_lock_supervisor.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/pll_lock_supervisor_if.sv
// Purpose : groups the PLL-side pins and supervisor status outputs of pll_lock_supervisor.
// Latency : none; plain wires with modports only.
// Backpressure: none; level signals only, no handshake.
//
// Signals:
//   pll_lock   raw PLL lock, asynchronous to the supervisor clock
//   pll_rst    active-high PLL reset
//   sys_rst_n  active-low downstream reset, released only while running
//   lock_ok    high only while running
//   fail       sticky failure flag after retries are exhausted
//   retry_cnt  lock timeouts since the last entry to the running state
//   loss_cnt   lock losses while running, saturating at 255
`timescale 1ns/1ps
interface pll_lock_supervisor_if;
    logic       pll_lock;
    logic       pll_rst;
    logic       sys_rst_n;
    logic       lock_ok;
    logic       fail;
    logic [3:0] retry_cnt;
    logic [7:0] loss_cnt;

    // Supervisor side
    modport master (
        input  pll_lock,
        output pll_rst,
        output sys_rst_n,
        output lock_ok,
        output fail,
        output retry_cnt,
        output loss_cnt
    );

    // PLL wrapper / reset tree side
    modport slave (
        output pll_lock,
        input  pll_rst,
        input  sys_rst_n,
        input  lock_ok,
        input  fail,
        input  retry_cnt,
        input  loss_cnt
    );
endinterface

// File: rtl/pll_lock_supervisor.sv
// Purpose : resets the video PLL, filters its lock and releases downstream reset after stable lock.
// Latency : lock to sys_rst_n release = LOCK_STABLE_CYCLES+3 edges; lock loss to re-reset = 3 edges.
// Backpressure: none; free-running supervisor, bounded retries then sticky fail.
//
// Ports:
//   clk    free-running init clock, independent of the PLL
//   rst_n  asynchronous active-low reset (synchronous deassertion assumed at the source)
//   sup    pll_lock_supervisor_if.master: pll_lock in; pll_rst, sys_rst_n, lock_ok,
//          fail, retry_cnt, loss_cnt out
`timescale 1ns/1ps
module pll_lock_supervisor #(
    parameter int RST_PULSE_CYCLES    = 100,
    parameter int LOCK_STABLE_CYCLES  = 1000,
    parameter int LOCK_TIMEOUT_CYCLES = 100000,
    parameter int MAX_RETRIES         = 7
) (
    input  logic                  clk,
    input  logic                  rst_n,
    pll_lock_supervisor_if.master sup
);

    // Counter sized to the largest terminal count, never narrower than 17 bits.
    localparam int MAX_A  = (RST_PULSE_CYCLES > LOCK_STABLE_CYCLES) ? RST_PULSE_CYCLES
                                                                     : LOCK_STABLE_CYCLES;
    localparam int MAX_P  = (MAX_A > LOCK_TIMEOUT_CYCLES) ? MAX_A : LOCK_TIMEOUT_CYCLES;
    localparam int CW     = ($clog2(MAX_P) > 17) ? $clog2(MAX_P) : 17;

    localparam logic [CW-1:0] RST_LAST     = CW'(RST_PULSE_CYCLES - 1);
    localparam logic [CW-1:0] STABLE_LAST  = CW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [3:0]    RETRY_MAX    = 4'(MAX_RETRIES);

    typedef enum logic [2:0] {
        ST_RESET     = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAIL      = 3'd4
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [1:0]    sync_q;
    logic          lock_s;
    logic [CW-1:0] cnt_q;
    logic [3:0]    retry_q;
    logic [7:0]    loss_q;
    logic          retry_inc;
    logic          loss_inc;
    logic          pll_rst_q;
    logic          sys_rst_n_q;
    logic          lock_ok_q;
    logic          fail_q;

    // Two-flop synchronizer; nothing downstream looks at the raw lock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], sup.pll_lock};
        end
    end

    assign lock_s = sync_q[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        retry_inc = 1'b0;
        loss_inc  = 1'b0;
        case (state_q)
            ST_RESET: begin
                if (cnt_q == RST_LAST) begin
                    state_d = ST_WAIT_LOCK;
                end
            end
            ST_WAIT_LOCK: begin
                // Lock wins over a timeout landing on the same cycle.
                if (lock_s) begin
                    state_d = ST_STABLE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    if (retry_q == RETRY_MAX) begin
                        state_d = ST_FAIL;
                    end else begin
                        retry_inc = 1'b1;
                        state_d   = ST_RESET;
                    end
                end
            end
            ST_STABLE: begin
                // A drop here only restarts the wait; the PLL is not re-reset.
                if (!lock_s) begin
                    state_d = ST_WAIT_LOCK;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!lock_s) begin
                    state_d  = ST_RESET;
                    loss_inc = 1'b1;
                end
            end
            ST_FAIL: begin
                state_d = ST_FAIL;
            end
            default: begin
                state_d = ST_RESET;
            end
        endcase
    end

    // Cycle counter: cleared on every state change, idle in RUN and FAIL.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (state_d != state_q) begin
            cnt_q <= '0;
        end else if (state_q == ST_RESET || state_q == ST_WAIT_LOCK || state_q == ST_STABLE) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    // retry_cnt counts timeouts since the last RUN; loss_cnt saturates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retry_q <= 4'd0;
            loss_q  <= 8'd0;
        end else begin
            if (state_d == ST_RUN && state_q != ST_RUN) begin
                retry_q <= 4'd0;
            end else if (retry_inc) begin
                retry_q <= retry_q + 4'd1;
            end
            if (loss_inc && loss_q != 8'hFF) begin
                loss_q <= loss_q + 8'd1;
            end
        end
    end

    // Outputs decode the next state so they switch on the same edge as the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pll_rst_q   <= 1'b1;
            sys_rst_n_q <= 1'b0;
            lock_ok_q   <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            pll_rst_q   <= (state_d == ST_RESET);
            sys_rst_n_q <= (state_d == ST_RUN);
            lock_ok_q   <= (state_d == ST_RUN);
            fail_q      <= (state_d == ST_FAIL);
        end
    end

    assign sup.pll_rst   = pll_rst_q;
    assign sup.sys_rst_n = sys_rst_n_q;
    assign sup.lock_ok   = lock_ok_q;
    assign sup.fail      = fail_q;
    assign sup.retry_cnt = retry_q;
    assign sup.loss_cnt  = loss_q;

endmodule
